// File: rtl/uart_pkg.sv
// Shared register map, status bit positions and receive FSM encoding for the UART port.
package uart_pkg;

  localparam logic [15:0] REG_DATA   = 16'd0;
  localparam logic [15:0] REG_STATUS = 16'd1;

  localparam int unsigned ST_READY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVERRUN = 2;
  localparam int unsigned ST_FRAMING = 3;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t IDLE  = 2'd0;
  localparam rx_state_t START = 2'd1;
  localparam rx_state_t DATA  = 2'd2;
  localparam rx_state_t STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with a one-bit-wider occupancy count; a push is accepted when full
// provided a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [PW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign count   = count_q;
  assign head    = mem[rptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset; the count gates every read of it.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 serial receiver: synchroniser, receive FSM, byte FIFO and
// data/status registers on the CPU bus.
module uart_rx_port
  import uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'h5a00,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [7:0]  data_in,
  input  logic        rx_serial,
  output logic [7:0]  data_out,
  output logic        hit,
  output logic        irq
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q;
  logic          rx_s, rx_prev_q, fall;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_sample;
  logic          ovr_q, ovr_d, fe_q, fe_d, irq_q;
  logic          push_ok, pop_ok, ovr_set, fe_set, wr_status;
  logic [7:0]    head, status;
  logic          empty, full;
  logic [PW:0]   count, count_next;

  assign rx_s = sync_q[1];
  assign fall = rx_prev_q & ~rx_s;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          stop_sample = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop frees the slot the same-cycle push lands in, so a full FIFO can still accept.
  assign pop_ok     = read_en & (address == BASE_ADDR + REG_DATA) & ~empty;
  assign push_ok    = stop_sample & rx_s & (~full | pop_ok);
  assign ovr_set    = stop_sample & rx_s & full & ~pop_ok;
  assign fe_set     = stop_sample & ~rx_s;
  assign wr_status  = write_en & (address == BASE_ADDR + REG_STATUS);
  assign ovr_d      = (ovr_q & ~(wr_status & data_in[2])) | ovr_set;
  assign fe_d       = (fe_q & ~(wr_status & data_in[3])) | fe_set;
  assign count_next = count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_serial};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ovr_q     <= ovr_d;
      fe_q      <= fe_d;
      irq_q     <= (count_next != '0);
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_ok),
    .pop     (pop_ok),
    .wdata   (shift_q),
    .head    (head),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  always_comb begin
    status             = 8'h00;
    status[ST_READY]   = ~empty;
    status[ST_FULL]    = full;
    status[ST_OVERRUN] = ovr_q;
    status[ST_FRAMING] = fe_q;
  end

  always_comb begin
    data_out = 8'hff;
    if (address == BASE_ADDR + REG_DATA)        data_out = empty ? 8'hff : head;
    else if (address == BASE_ADDR + REG_STATUS) data_out = status;
  end

  assign hit = (address == BASE_ADDR + REG_DATA) | (address == BASE_ADDR + REG_STATUS);
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Bench for uart_rx_port: a queue-based receiver model checked against the DUT every cycle,
// plus literal register reads along the directed frame sequence.
module tb_uart_rx_port;

  localparam logic [15:0] BASE  = 16'h5a00;
  localparam logic [15:0] STAT  = 16'h5a01;
  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;
  // Line low to stop-sample edge: 2 sync flops, edge detect, half bit, 8 data bits, stop bit.
  localparam int          STOP_LAT = 2 + 1 + CPB / 2 + 9 * CPB;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] address = 16'h0000;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        rx_serial = 1'b1;
  logic [7:0]  data_out;
  logic        hit;
  logic        irq;

  uart_rx_port #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .address   (address),
    .write_en  (write_en),
    .read_en   (read_en),
    .data_in   (data_in),
    .rx_serial (rx_serial),
    .data_out  (data_out),
    .hit       (hit),
    .irq       (irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic        stop;
  } ev_t;

  ev_t         evq[$];
  logic [7:0]  mq[$];
  logic        m_ovr = 1'b0;
  logic        m_fe = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        abort = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    if (a == BASE) return (mq.size() == 0) ? 8'hff : mq[0];
    if (a == STAT) return {4'b0, m_fe, m_ovr, mq.size() == DEPTH, mq.size() != 0};
    return 8'hff;
  endfunction

  // Model: bus effects and frame completions applied at the clock edge they occur on.
  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      mq.delete();
      evq.delete();
      m_ovr = 1'b0;
      m_fe  = 1'b0;
    end else begin
      logic pop;
      cyc++;
      pop = read_en && address == BASE && mq.size() != 0;
      if (write_en && address == STAT) begin
        if (data_in[2]) m_ovr = 1'b0;
        if (data_in[3]) m_fe = 1'b0;
      end
      if (pop) mq.delete(0);
      if (evq.size() != 0 && evq[0].cyc == cyc) begin
        if (evq[0].stop) begin
          if (mq.size() < DEPTH) mq.push_back(evq[0].data);
          else m_ovr = 1'b1;
        end else begin
          m_fe = 1'b1;
        end
        evq.delete(0);
      end
    end
  end

  initial forever begin
    @(negedge clock);
    chk("data_out", data_out, exp_read(address));
    chk("hit", {7'b0, hit}, {7'b0, (address == BASE || address == STAT)});
    chk("irq", {7'b0, irq}, {7'b0, mq.size() != 0});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic peek(input logic [15:0] a, input logic [7:0] exp, input string name);
    address = a;
    @(negedge clock);
    chk(name, data_out, exp);
    tick();
  endtask

  task automatic rd_pop(input logic [7:0] exp, input string name);
    address = BASE;
    read_en = 1'b1;
    @(negedge clock);
    chk(name, data_out, exp);
    tick();
    read_en = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address  = a;
    data_in  = d;
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    ev_t e;
    bits   = {stop, b, 1'b0};
    e.cyc  = cyc + STOP_LAT;
    e.data = b;
    e.stop = stop;
    evq.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rx_serial = bits[i];
      for (int k = 0; k < CPB; k++) begin
        if (abort) begin
          rx_serial = 1'b1;
          return;
        end
        tick();
      end
    end
    rx_serial = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    repeat (3) tick();
    peek(STAT, 8'h00, "reset_status");
    reset_n = 1'b1;
    tick();
    peek(STAT, 8'h00, "idle_status");
    peek(BASE, 8'hff, "idle_data");
    peek(16'h5a02, 8'hff, "unmapped_read");

    // Single frame, then pop it.
    send_frame(8'h48, 1'b1);
    peek(STAT, 8'h01, "one_status");
    peek(BASE, 8'h48, "one_data");
    rd_pop(8'h48, "one_pop");
    peek(STAT, 8'h00, "one_status_after");
    peek(BASE, 8'hff, "one_data_after");

    // Five frames into a four-entry FIFO.
    send_frame(8'h48, 1'b1);
    send_frame(8'h65, 1'b1);
    send_frame(8'h6c, 1'b1);
    send_frame(8'h6c, 1'b1);
    send_frame(8'h6f, 1'b1);
    peek(STAT, 8'h07, "ovr_status");
    rd_pop(8'h48, "ovr_pop0");
    rd_pop(8'h65, "ovr_pop1");
    rd_pop(8'h6c, "ovr_pop2");
    rd_pop(8'h6c, "ovr_pop3");
    peek(STAT, 8'h04, "ovr_drained");
    rd_pop(8'hff, "empty_pop");
    wr(STAT, 8'h04);
    peek(STAT, 8'h00, "ovr_cleared");

    // Framing error; a write to the data register must not clear it.
    send_frame(8'h21, 1'b0);
    peek(STAT, 8'h08, "fe_status");
    wr(BASE, 8'hff);
    peek(STAT, 8'h08, "fe_data_write_ignored");
    wr(STAT, 8'h08);
    peek(STAT, 8'h00, "fe_cleared");

    // Short low pulse is rejected at the start-bit check.
    rx_serial = 1'b0;
    repeat (4) tick();
    rx_serial = 1'b1;
    repeat (200) tick();
    peek(STAT, 8'h00, "glitch_status");

    // Full FIFO, pop on the stop-sample cycle of the fifth frame.
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    peek(STAT, 8'h03, "full_status");
    fork
      send_frame(8'h0a, 1'b1);
      begin
        repeat (STOP_LAT - 1) tick();
        rd_pop(8'h01, "sim_pop");
      end
    join
    peek(STAT, 8'h03, "sim_status");
    rd_pop(8'h02, "sim_pop1");
    rd_pop(8'h03, "sim_pop2");
    rd_pop(8'h04, "sim_pop3");
    rd_pop(8'h0a, "sim_pop4");
    peek(STAT, 8'h00, "sim_empty");

    // Framing error and its clear on the same edge: the error wins.
    fork
      send_frame(8'h33, 1'b0);
      begin
        repeat (STOP_LAT - 1) tick();
        wr(STAT, 8'h08);
      end
    join
    peek(STAT, 8'h08, "fe_set_wins");
    wr(STAT, 8'h08);
    peek(STAT, 8'h00, "fe_cleared2");

    // Reset during data bit 3.
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (CPB * 4 + 8) tick();
        reset_n   = 1'b0;
        abort     = 1'b1;
        rx_serial = 1'b1;
        #1;
        chk("reset_async_irq", {7'b0, irq}, 8'h00);
        repeat (3) tick();
        reset_n = 1'b1;
      end
    join
    abort = 1'b0;
    peek(STAT, 8'h00, "post_reset_status");
    peek(BASE, 8'hff, "post_reset_data");
    repeat (200) tick();
    peek(STAT, 8'h00, "no_partial_push");
    send_frame(8'h64, 1'b1);
    peek(STAT, 8'h01, "after_reset_status");
    rd_pop(8'h64, "after_reset_pop");
    peek(STAT, 8'h00, "final_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_port.md
Name: uart_rx_port

Overview:
- Memory-mapped serial receiver. It is the input-direction counterpart of the transmit-only UART stub at 16'h5a00.
- It deserialises 8N1 frames from an external rx line and buffers received bytes in a small FIFO.
- The CPU reads data and status over the same address/data bus used by memory.
- The top level muxes data_out onto the CPU read path whenever hit is high.

Parameters:
- BASE_ADDR, 16'h5a00, base address. Data register at BASE_ADDR, status register at BASE_ADDR+1.
- CLKS_PER_BIT, 16, clock cycles per serial bit. Must be at least 4.
- FIFO_DEPTH, 4, receive FIFO entries. Must be a power of 2.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  16  CPU bus address.
- write_en  in  1  CPU write strobe, sampled at posedge.
- read_en  in  1  CPU read strobe, sampled at posedge; pops the FIFO on a data-register read.
- data_in  in  8  CPU write data.
- rx_serial  in  1  asynchronous serial input; idle high.
- data_out  out  8  combinational read data for the addressed register.
- hit  out  1  combinational; high when address == BASE_ADDR or BASE_ADDR+1.
- irq  out  1  registered; equals status bit0 (rx_ready).

Behaviour:
- Reset values: FIFO empty; all status flags 0; FSM in IDLE; synchroniser flops 1; irq 0.
- Input path:
  - rx_serial passes through a 2-flop synchroniser, giving rx_s.
  - Falling-edge detection uses one more registered copy of rx_s.
- Receive FSM, with bit counter 0..7 and cycle counter 0..CLKS_PER_BIT-1:
  - IDLE: on an rx_s falling edge, load cnt=0 and go to START.
  - START: when cnt reaches CLKS_PER_BIT/2-1, sample rx_s.
    - Low: reset cnt, bit=0, go to DATA.
    - High: glitch; return to IDLE with nothing recorded.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - High: push the byte.
    - Low: set framing_err and discard the byte.
    - Either way, return to IDLE.
  - A new start is accepted only on a fresh falling edge. A line held low after a framing error produces no new frame.
- Push timing and FIFO rules:
  - The push happens on the same posedge as the stop sample.
  - The byte is readable on the next cycle.
  - If the FIFO is full and no pop occurs that cycle: drop the byte, set overrun, leave the FIFO unchanged.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This holds even when the FIFO is full; overrun is not set in that case.
- Read path (combinational):
  - Address BASE_ADDR: data_out = FIFO head, or 8'hff if empty.
  - Address BASE_ADDR+1: data_out = {4'b0, framing_err, overrun, full, ready}, where ready = not empty.
  - Any other address: data_out = 8'hff.
- Pop: on read_en && address==BASE_ADDR && !empty, advance the read pointer. A read while empty has no effect.
- Writes:
  - write_en && address==BASE_ADDR+1: write-1-to-clear. data_in[2] clears overrun; data_in[3] clears framing_err.
  - A flag set and a clear in the same cycle leaves the flag set.
  - Writes to BASE_ADDR are ignored.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is one bit wider, so full and empty are distinguishable.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is ever pushed.

Decomposition:
- Shared package uart_pkg holds:
  - register offsets REG_DATA=0, REG_STATUS=1;
  - status bit positions ST_READY=0, ST_FULL=1, ST_OVERRUN=2, ST_FRAMING=3;
  - FSM state enum {IDLE, START, DATA, STOP}.
- Sub-module uart_rx_fifo: synchronous FIFO with push/pop/head/empty/full, parameterised on depth. It is reusable by a future TX side.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Send frame 0x48 on rx_serial -> status reads 8'h01 and data reads 8'h48; after one pop, status reads 8'h00 and data reads 8'hff.
- Send 0x48, 0x65, 0x6c, 0x6c, 0x6f with no reads -> status 8'h07 (ready, full, overrun); four pops return 48, 65, 6c, 6c; 0x6f is lost. Writing 8'h04 to status then yields 8'h00 with the FIFO empty.
- Send 0x21 with the stop bit driven 0 -> status bit3 set and FIFO empty. Writing 8'h08 clears bit3.
- Drive rx_serial low for 4 clocks, then high -> no byte is received and status stays 8'h00.
- With the FIFO full, pop on the exact stop-sample cycle of a fifth frame (0x0a) -> overrun stays 0, count stays 4, and the last entry read is 0x0a.
- Assert reset_n low during DATA bit 3 of a frame, then release -> all outputs at reset values; the next clean frame 0x64 is received correctly.
